// File: rtl/multicycle_mem_responder_pkg.sv
// Shared memory-access encodings for the multicycle core and its memory responder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
// Contents: funct3 load/store format codes plus request legality helpers.
package multicycle_mem_responder_pkg;

  // funct3 load/store width encodings, shared with the core's load/store logic
  localparam logic [2:0] MEM_FMT_B  = 3'b000;
  localparam logic [2:0] MEM_FMT_H  = 3'b001;
  localparam logic [2:0] MEM_FMT_W  = 3'b010;
  localparam logic [2:0] MEM_FMT_BU = 3'b100;
  localparam logic [2:0] MEM_FMT_HU = 3'b101;

  // Unsigned formats only make sense for loads; anything unlisted is reserved.
  function automatic logic mem_fmt_illegal(input logic [2:0] fmt, input logic is_write);
    case (fmt)
      MEM_FMT_B, MEM_FMT_H, MEM_FMT_W: mem_fmt_illegal = 1'b0;
      MEM_FMT_BU, MEM_FMT_HU:          mem_fmt_illegal = is_write;
      default:                         mem_fmt_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [2:0] fmt, input logic [1:0] lsb);
    case (fmt)
      MEM_FMT_H, MEM_FMT_HU: mem_misaligned = lsb[0];
      MEM_FMT_W:             mem_misaligned = (lsb != 2'b00);
      default:               mem_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_mem_responder_ram.sv
// Word-wide single-port RAM with per-byte write enables and registered read data.
// Latency: read data appears the cycle after addr is presented.
// Backpressure: none; accepts a read and an optional write every cycle.
// Ports: clock, addr (word address), byte_en, wdata, write_enable, rdata.
module mem_word_ram #(
  parameter int    ADDR_WIDTH = 16,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            byte_en,
  input  logic [31:0]           wdata,
  input  logic                  write_enable,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Read-before-write: a same-cycle read returns the old word.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/multicycle_mem_responder.sv
// Memory responder for the multicycle core: one request at a time, byte-lane stores, formatted loads.
// Latency: accept -> resp_valid after WAIT_CYCLES+2 cycles (1 cycle for rejected requests).
// Backpressure: req_ready only in IDLE; throughput one request per WAIT_CYCLES+3 cycles.
// Ports: clock/reset (sync, active-high), req_* request handshake, resp_* one-cycle response.
module multicycle_mem_responder
  import multicycle_mem_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 16,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic [2:0]  req_format,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        fmt_q, fmt_d;
  logic              write_q, write_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_error_q, resp_error_d;

  logic              req_err;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign req_ready = (state_q == S_IDLE) & ~reset;

  // Only meaningful in the accept cycle; the request ports are never looked at otherwise.
  assign req_err = mem_misaligned(req_format, req_address[1:0])
                 | mem_fmt_illegal(req_format, req_write)
                 | ((req_address >> (ADDR_WIDTH + 2)) != 32'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fmt_d        = fmt_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_address;
          wdata_d = req_write_data;
          fmt_d   = req_format;
          write_d = req_write;
          if (req_err) begin
            // Rejected requests skip the RAM entirely.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACCESS: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fmt_q        <= MEM_FMT_W;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fmt_q        <= fmt_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Store lane steering: sub-word data is replicated so the byte enables pick the lane.
  always_comb begin
    ram_we    = (state_q == S_ACCESS) & write_q & ~reset;
    ram_be    = 4'b1111;
    ram_wdata = wdata_q;
    case (fmt_q)
      MEM_FMT_B: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      MEM_FMT_H: begin
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  mem_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clock        (clock),
    .addr         (addr_q[ADDR_WIDTH+1:2]),
    .byte_en      (ram_be),
    .wdata        (ram_wdata),
    .write_enable (ram_we),
    .rdata        (ram_rdata)
  );

  // Load formatting works on the RAM word that lands in the RESP cycle.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = ram_rdata[7:0];
      2'd1:    ld_byte = ram_rdata[15:8];
      2'd2:    ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (fmt_q)
      MEM_FMT_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_FMT_BU: ld_data = {24'd0, ld_byte};
      MEM_FMT_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_FMT_HU: ld_data = {16'd0, ld_half};
      default:    ld_data = ram_rdata;
    endcase
  end

  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_read_data = (resp_valid_q && !resp_error_q && !write_q) ? ld_data : 32'd0;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench for multicycle_mem_responder: one instance with WAIT_CYCLES=2, one with 0.
// Expected responses are queued when a request is accepted and popped when resp_valid is seen.
module tb_multicycle_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          lat;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [2:0]  req_format;

  logic        rv2, rdy2, resp_valid2, resp_error2;
  logic [31:0] resp_data2;
  logic        rv0, rdy0, resp_valid0, resp_error0;
  logic [31:0] resp_data0;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_resp2 = 0;
  int   n_resp0 = 0;
  exp_t q2[$];
  exp_t q0[$];

  multicycle_mem_responder #(.ADDR_WIDTH(16), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .clock(clock), .reset(reset),
    .req_valid(rv2), .req_ready(rdy2), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data), .req_format(req_format),
    .resp_valid(resp_valid2), .resp_read_data(resp_data2), .resp_error(resp_error2)
  );

  multicycle_mem_responder #(.ADDR_WIDTH(16), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(rv0), .req_ready(rdy0), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data), .req_format(req_format),
    .resp_valid(resp_valid0), .resp_read_data(resp_data0), .resp_error(resp_error0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitors, sampling on the falling edge.
  bit pulse2 = 0;
  always @(negedge clock) begin
    exp_t e;
    if (pulse2) begin
      chk("pulse_width_w2", 32'(resp_valid2), 32'd0);
      pulse2 = 0;
    end
    if (resp_valid2 === 1'b1) begin
      n_resp2++;
      chk("resp_expected_w2", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("data_w2", resp_data2, e.data);
        chk("error_w2", 32'(resp_error2), 32'(e.err));
        chk("latency_w2", 32'(cyc - e.cyc), 32'(e.lat));
        pulse2 = 1;
      end
    end
  end

  bit pulse0 = 0;
  always @(negedge clock) begin
    exp_t e;
    if (pulse0) begin
      chk("pulse_width_w0", 32'(resp_valid0), 32'd0);
      pulse0 = 0;
    end
    if (resp_valid0 === 1'b1) begin
      n_resp0++;
      chk("resp_expected_w0", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("data_w0", resp_data0, e.data);
        chk("error_w0", 32'(resp_error0), 32'(e.err));
        chk("latency_w0", 32'(cyc - e.cyc), 32'(e.lat));
        pulse0 = 1;
      end
    end
  end

  // d=0 targets the WAIT_CYCLES=2 instance, d=1 the WAIT_CYCLES=0 instance.
  // Returns on the falling edge of the cycle after the accept, with req_* driven to X.
  task automatic send(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f, input logic [31:0] ed, input logic ee,
                      input int lat, input bit push);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clock);
    req_write      = w;
    req_address    = a;
    req_write_data = wd;
    req_format     = f;
    if (d == 0) rv2 = 1'b1; else rv0 = 1'b1;
    while (!((d == 0) ? rdy2 : rdy0) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      chk("accept_timeout", 32'(guard), 32'd0);
      rv2 = 1'b0;
      rv0 = 1'b0;
      return;
    end
    e.data = ed; e.err = ee; e.cyc = cyc; e.lat = lat;
    if (push) begin
      if (d == 0) q2.push_back(e); else q0.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    rv2 = 1'b0;
    rv0 = 1'b0;
    req_write      = 1'bx;
    req_address    = 'x;
    req_write_data = 'x;
    req_format     = 'x;
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while (((d == 0) ? q2.size() : q0.size()) != 0 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    chk("drain_done", 32'((d == 0) ? q2.size() : q0.size()), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last;
    int nacc;
    int base;
    reset = 1'b1;
    rv2 = 1'b0;
    rv0 = 1'b0;
    req_write = 1'b0;
    req_address = '0;
    req_write_data = '0;
    req_format = 3'b010;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(rdy2), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid2), 32'd0);
    chk("rst_resp_error", 32'(resp_error2), 32'd0);
    chk("rst_resp_data", resp_data2, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(rdy2), 32'd1);

    // Word store then load
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 4, 1'b1);
    drain(0);
    send(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 4, 1'b1);
    drain(0);

    // Sub-word loads with sign/zero extension
    send(0, 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 4, 1'b1);
    send(0, 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0, 4, 1'b1);
    send(0, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 4, 1'b1);
    send(0, 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, 4, 1'b1);
    drain(0);

    // Byte and half stores
    send(0, 1'b1, 32'h11, 32'h000000AA, 3'b000, 32'h0, 1'b0, 4, 1'b1);
    send(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADAAEF, 1'b0, 4, 1'b1);
    send(0, 1'b1, 32'h12, 32'h00001234, 3'b001, 32'h0, 1'b0, 4, 1'b1);
    send(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 1'b0, 4, 1'b1);
    drain(0);

    // Rejected requests: one cycle to response, no RAM side effect
    send(0, 1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1, 1, 1'b1);
    send(0, 1'b1, 32'h12, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1, 1, 1'b1);
    send(0, 1'b0, 32'h0004_0000, 32'h0, 3'b010, 32'h0, 1'b1, 1, 1'b1);
    send(0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1, 1'b1);
    send(0, 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1, 1, 1'b1);
    send(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 1'b0, 4, 1'b1);
    drain(0);

    // Reset while a store sits in WAIT
    send(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 4, 1'b1);
    drain(0);
    base = n_resp2;
    send(0, 1'b1, 32'h20, 32'h12345678, 3'b010, 32'h0, 1'b0, 4, 1'b0);
    reset = 1'b1;
    #1;
    chk("ready_in_reset", 32'(rdy2), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ready_after_reset_pulse", 32'(rdy2), 32'd1);
    repeat (8) @(negedge clock);
    chk("no_resp_after_reset", 32'(n_resp2 - base), 32'd0);
    send(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 4, 1'b1);
    drain(0);

    // Zero-wait instance: single request, then continuous back-to-back requests
    send(1, 1'b1, 32'h40, 32'hA5A55A5A, 3'b010, 32'h0, 1'b0, 2, 1'b1);
    drain(1);
    send(1, 1'b0, 32'h40, 32'h0, 3'b001, 32'h00005A5A, 1'b0, 2, 1'b1);
    drain(1);
    base = n_resp0;
    last = -1;
    nacc = 0;
    @(negedge clock);
    req_write = 1'b0;
    req_address = 32'h40;
    req_write_data = 32'h0;
    req_format = 3'b010;
    rv0 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (rdy0) begin
        exp_t e;
        e.data = 32'hA5A55A5A; e.err = 1'b0; e.cyc = cyc; e.lat = 2;
        q0.push_back(e);
        if (last >= 0) chk("accept_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        nacc++;
      end
      @(negedge clock);
    end
    rv0 = 1'b0;
    drain(1);
    chk("accept_count", 32'(nacc), 32'd6);
    chk("resp_count", 32'(n_resp0 - base), 32'(nacc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
